// File: rtl/dm_access_sequencer_pkg.sv
// Shared op codes, FSM state encoding and alignment helper for the data-memory access sequencer.
package dm_access_sequencer_pkg;

   localparam int unsigned DM_OP_W  = 3;
   localparam int unsigned DMS_ST_W = 3;

   localparam logic [DM_OP_W-1:0] DM_OP_WD = 3'd0;
   localparam logic [DM_OP_W-1:0] DM_OP_SB = 3'd1;
   localparam logic [DM_OP_W-1:0] DM_OP_SH = 3'd2;
   localparam logic [DM_OP_W-1:0] DM_OP_UB = 3'd3;
   localparam logic [DM_OP_W-1:0] DM_OP_UH = 3'd4;

   typedef enum logic [DMS_ST_W-1:0] {
      DMS_ST_IDLE  = 3'd0,
      DMS_ST_READ  = 3'd1,
      DMS_ST_WAIT  = 3'd2,
      DMS_ST_WRITE = 3'd3,
      DMS_ST_RESP  = 3'd4
   } dms_st_e;

   // Word accesses need a 4-byte aligned address, half accesses an even one.
   function automatic logic dm_misaligned(input logic [DM_OP_W-1:0] op, input logic [1:0] lane);
      case (op)
         DM_OP_WD:           return (lane != 2'd0);
         DM_OP_SH, DM_OP_UH: return lane[0];
         default:            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte/half lane extraction for loads and lane merge for read-modify-write stores (little-endian).
module dm_lane_merge
   import dm_access_sequencer_pkg::*;
(
   input  logic [DM_OP_W-1:0] op,
   input  logic [1:0]         lane,
   input  logic [31:0]        word,
   input  logic [31:0]        wdata,
   output logic [31:0]        load_val,
   output logic [31:0]        store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] merged_b;
   logic [31:0] merged_h;

   // Select the addressed byte/half and build the merged words for both widths.
   always_comb begin
      byte_sel = word[7:0];
      merged_b = word;
      case (lane)
         2'd0: begin byte_sel = word[7:0];   merged_b[7:0]   = wdata[7:0]; end
         2'd1: begin byte_sel = word[15:8];  merged_b[15:8]  = wdata[7:0]; end
         2'd2: begin byte_sel = word[23:16]; merged_b[23:16] = wdata[7:0]; end
         default: begin byte_sel = word[31:24]; merged_b[31:24] = wdata[7:0]; end
      endcase
      merged_h = word;
      if (lane[1]) begin
         half_sel        = word[31:16];
         merged_h[31:16] = wdata[15:0];
      end else begin
         half_sel        = word[15:0];
         merged_h[15:0]  = wdata[15:0];
      end
   end

   // Extend loads by op; stores with unsigned codes merge exactly like their signed counterparts.
   always_comb begin
      load_val   = word;
      store_word = wdata;
      case (op)
         DM_OP_SB: begin load_val = {{24{byte_sel[7]}}, byte_sel};  store_word = merged_b; end
         DM_OP_UB: begin load_val = {24'd0, byte_sel};              store_word = merged_b; end
         DM_OP_SH: begin load_val = {{16{half_sel[15]}}, half_sel}; store_word = merged_h; end
         DM_OP_UH: begin load_val = {16'd0, half_sel};              store_word = merged_h; end
         default:  begin load_val = word;                           store_word = wdata;    end
      endcase
   end

endmodule

// File: rtl/dm_access_sequencer.sv
// Multi-cycle load/store sequencer in front of a single-port, 1-cycle-read synchronous data RAM.
module dm_access_sequencer
   import dm_access_sequencer_pkg::*;
#(
   parameter int unsigned MEM_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   input  logic [DM_OP_W-1:0] req_op,
   input  logic               req_we,
   input  logic [31:0]        req_addr,
   input  logic [31:0]        req_wdata,
   output logic               busy,
   output logic               done,
   output logic [31:0]        rdata,
   output logic               misalign,
   output logic               mem_en,
   output logic               mem_we,
   output logic [MEM_AW-1:0]  mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);

   dms_st_e              state;
   logic [DM_OP_W-1:0]   op_q;
   logic                 we_q;
   logic [MEM_AW+1:0]    addr_q;
   logic [31:0]          wdata_q;
   logic [31:0]          wword_q;
   logic [31:0]          load_val;
   logic [31:0]          merge_word;
   logic                 req_mis;
   logic                 unused_addr_hi;

   // Byte address bits above the RAM size are don't-care.
   assign unused_addr_hi = ^req_addr[31:MEM_AW+2];
   assign req_mis        = dm_misaligned(req_op, req_addr[1:0]);

   dm_lane_merge u_lane_merge (
      .op         (op_q),
      .lane       (addr_q[1:0]),
      .word       (mem_rdata),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (merge_word)
   );

   // Access FSM with request latches and registered result/response state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DMS_ST_IDLE;
         op_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wword_q  <= '0;
         rdata    <= '0;
         misalign <= 1'b0;
      end else begin
         case (state)
            DMS_ST_IDLE: begin
               if (req_valid) begin
                  op_q     <= req_op;
                  we_q     <= req_we;
                  addr_q   <= req_addr[MEM_AW+1:0];
                  wdata_q  <= req_wdata;
                  misalign <= req_mis;
                  if (req_mis) begin
                     state <= DMS_ST_RESP;
                  end else if (req_we && (req_op == DM_OP_WD)) begin
                     wword_q <= req_wdata;
                     state   <= DMS_ST_WRITE;
                  end else begin
                     state <= DMS_ST_READ;
                  end
               end
            end
            DMS_ST_READ:  state <= DMS_ST_WAIT;
            DMS_ST_WAIT: begin
               if (we_q) begin
                  wword_q <= merge_word;
                  state   <= DMS_ST_WRITE;
               end else begin
                  rdata <= load_val;
                  state <= DMS_ST_RESP;
               end
            end
            DMS_ST_WRITE: state <= DMS_ST_RESP;
            DMS_ST_RESP:  state <= DMS_ST_IDLE;
            default:      state <= DMS_ST_IDLE;
         endcase
      end
   end

   // RAM strobes come from state only and are blocked during reset so an abandoned store never lands.
   assign busy      = (state != DMS_ST_IDLE);
   assign done      = (state == DMS_ST_RESP);
   assign mem_en    = ~rst & ((state == DMS_ST_READ) | (state == DMS_ST_WRITE));
   assign mem_we    = ~rst & (state == DMS_ST_WRITE);
   assign mem_addr  = addr_q[MEM_AW+1:2];
   assign mem_wdata = wword_q;

endmodule

// File: tb/tb_dm_access_sequencer.sv
// Self-checking bench: byte-array reference memory model, per-cycle compare, directed + random requests.
module tb_dm_access_sequencer;
   import dm_access_sequencer_pkg::*;

   localparam int unsigned MEM_AW = 10;
   localparam int unsigned NW     = 1 << MEM_AW;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic [DM_OP_W-1:0] req_op;
   logic               req_we;
   logic [31:0]        req_addr;
   logic [31:0]        req_wdata;
   logic               busy, done, misalign, mem_en, mem_we;
   logic [31:0]        rdata, mem_wdata, mem_rdata;
   logic [MEM_AW-1:0]  mem_addr;

   int total = 0;
   int bad   = 0;
   logic load_ram;
   logic chk_en = 1'b0;
   int en_cnt = 0;
   int we_cnt = 0;

   always #5 clk = ~clk;

   dm_access_sequencer #(.MEM_AW(MEM_AW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
      .misalign(misalign), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] init_word(input int unsigned i);
      if (i == 4) return 32'h1122_3344;
      if (i == 8) return 32'h80FF_7F01;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // RAM: synchronous write, 1-cycle registered read.
   logic [31:0] ram [NW];
   always @(posedge clk) begin
      if (load_ram) begin
         for (int i = 0; i < int'(NW); i++) ram[i] <= init_word(i);
      end else begin
         if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
         if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
      end
   end

   always @(negedge clk) begin
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
   end

   // Reference model: byte-addressed memory and per-transaction timing from op/we/alignment.
   logic [7:0]  ref_b [4*NW];
   bit          m_busy = 0, m_st = 0, m_mis = 0;
   int          m_left = 0, m_lat = 0;
   logic [31:0] m_rdata = '0, m_load = '0, m_wword = '0;
   logic [9:0]  m_waddr = '0;
   int unsigned m_wbase = 0;

   always @(posedge clk) begin
      if (load_ram) begin
         for (int w = 0; w < int'(NW); w++) begin
            logic [31:0] t;
            t = init_word(w);
            for (int k = 0; k < 4; k++) ref_b[w*4+k] = t[8*k +: 8];
         end
      end
      if (rst) begin
         m_busy = 0; m_left = 0; m_rdata = '0; m_mis = 0;
      end else if (!m_busy) begin
         if (req_valid) begin
            int unsigned a, sz;
            logic [31:0] v;
            logic [7:0] tmp [4];
            a  = req_addr & 32'hFFF;
            sz = (req_op == DM_OP_WD) ? 4 : ((req_op == DM_OP_SB || req_op == DM_OP_UB) ? 1 : 2);
            m_mis = (sz == 4) ? (a % 4 != 0) : ((sz == 2) ? (a % 2 != 0) : 1'b0);
            m_st  = req_we;
            m_lat = m_mis ? 1 : ((req_we && sz == 4) ? 2 : (req_we ? 4 : 3));
            m_left = m_lat;
            m_busy = 1;
            m_waddr = 10'(a / 4);
            m_wbase = a - (a % 4);
            if (!m_mis) begin
               v = '0;
               for (int k = 0; k < int'(sz); k++) v = v | (32'(ref_b[a+k]) << (8*k));
               if (req_op == DM_OP_SB && v[7])  v = v | 32'hFFFF_FF00;
               if (req_op == DM_OP_SH && v[15]) v = v | 32'hFFFF_0000;
               m_load = v;
               for (int k = 0; k < 4; k++) tmp[k] = ref_b[m_wbase+k];
               for (int k = 0; k < int'(sz); k++) tmp[a-m_wbase+k] = 8'(req_wdata >> (8*k));
               m_wword = {tmp[3], tmp[2], tmp[1], tmp[0]};
            end
         end
      end else begin
         if (m_left == 2 && !m_mis && m_st)
            for (int k = 0; k < 4; k++) ref_b[m_wbase+k] = 8'(m_wword >> (8*k));
         if (m_left == 2 && !m_mis && !m_st) m_rdata = m_load;
         m_left--;
         if (m_left == 0) m_busy = 0;
      end
   end

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         bit e_done, e_rd, e_wr;
         e_done = m_busy && m_left == 1;
         e_rd   = !rst && m_busy && !m_mis && (!m_st || m_lat == 4) && m_left == m_lat;
         e_wr   = !rst && m_busy && !m_mis && m_st && m_left == 2;
         chk("busy",  32'(busy),  32'(m_busy));
         chk("done",  32'(done),  32'(e_done));
         if (e_done) chk("misalign", 32'(misalign), 32'(m_mis));
         chk("rdata", rdata, m_rdata);
         chk("mem_en", 32'(mem_en), 32'(e_rd || e_wr));
         chk("mem_we", 32'(mem_we), 32'(e_wr));
         if (e_rd || e_wr) chk("mem_addr", 32'(mem_addr), 32'(m_waddr));
         if (e_wr) chk("mem_wdata", mem_wdata, m_wword);
      end
   end

   // Issue one request, scramble the request fields while busy, return latency and response.
   task automatic do_req(input logic [2:0] op, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input bit hold,
                         output int lat, output logic [31:0] rd, output logic mis);
      int n;
      bit got;
      req_op = op; req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      n = 0; got = 0;
      while (n < 20 && !got) begin
         @(negedge clk);
         n++;
         if (done) got = 1;
         else if (n == 2) begin
            req_op    = 3'($urandom_range(0, 4));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
         end
      end
      lat = n - 1; rd = rdata; mis = misalign;
      if (!got) chk("done_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   initial begin
      int lat, e0, w0;
      logic [31:0] rd;
      logic mis;
      rst = 1'b1; load_ram = 1'b1; req_valid = 1'b0; req_op = '0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0;
      @(posedge clk); #1 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; load_ram = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;

      // Sub-word and word loads from the 0x20 word.
      do_req(DM_OP_SB, 1'b0, 32'h23, 32'h0, 0, lat, rd, mis);
      chk("sb_rdata", rd, 32'hFFFF_FF80); chk("sb_lat", 32'(lat), 32'd3);
      do_req(DM_OP_UB, 1'b0, 32'h23, 32'h0, 0, lat, rd, mis);
      chk("ub_rdata", rd, 32'h0000_0080); chk("ub_lat", 32'(lat), 32'd3);
      do_req(DM_OP_SH, 1'b0, 32'h22, 32'h0, 0, lat, rd, mis);
      chk("sh_rdata", rd, 32'hFFFF_80FF); chk("sh_lat", 32'(lat), 32'd3);
      do_req(DM_OP_UH, 1'b0, 32'h20, 32'h0, 0, lat, rd, mis);
      chk("uh_rdata", rd, 32'h0000_7F01); chk("uh_lat", 32'(lat), 32'd3);
      do_req(DM_OP_WD, 1'b0, 32'h20, 32'h0, 0, lat, rd, mis);
      chk("wd_rdata", rd, 32'h80FF_7F01); chk("wd_lat", 32'(lat), 32'd3);

      // Byte store read-merge-write.
      e0 = en_cnt; w0 = we_cnt;
      do_req(DM_OP_SB, 1'b1, 32'h11, 32'hAAAA_AAAA, 0, lat, rd, mis);
      chk("sbst_lat", 32'(lat), 32'd4);
      chk("sbst_ram", ram[4], 32'h1122_AA44);
      chk("sbst_en_cnt", 32'(en_cnt - e0), 32'd2);
      chk("sbst_we_cnt", 32'(we_cnt - w0), 32'd1);
      chk("sbst_rdata_held", rd, 32'h80FF_7F01);

      // Word store: write only.
      e0 = en_cnt; w0 = we_cnt;
      do_req(DM_OP_WD, 1'b1, 32'h14, 32'hDEAD_BEEF, 0, lat, rd, mis);
      chk("wdst_lat", 32'(lat), 32'd2);
      chk("wdst_ram", ram[5], 32'hDEAD_BEEF);
      chk("wdst_en_cnt", 32'(en_cnt - e0), 32'd1);
      chk("wdst_rdata_held", rd, 32'h80FF_7F01);

      // Misaligned accesses.
      e0 = en_cnt;
      do_req(DM_OP_SH, 1'b0, 32'h21, 32'h0, 0, lat, rd, mis);
      chk("mis_sh_flag", 32'(mis), 32'd1); chk("mis_sh_lat", 32'(lat), 32'd1);
      do_req(DM_OP_WD, 1'b1, 32'h22, 32'h1234_5678, 0, lat, rd, mis);
      chk("mis_wd_flag", 32'(mis), 32'd1); chk("mis_wd_lat", 32'(lat), 32'd1);
      chk("mis_en_cnt", 32'(en_cnt - e0), 32'd0);
      chk("mis_ram", ram[8], 32'h80FF_7F01);
      chk("mis_rdata_held", rd, 32'h80FF_7F01);
      do_req(DM_OP_UH, 1'b0, 32'h22, 32'h0, 0, lat, rd, mis);
      chk("mis_cleared", 32'(mis), 32'd0);
      chk("uh_hi_rdata", rd, 32'h0000_80FF);

      // Reset during WAIT of a half store abandons it.
      w0 = we_cnt;
      req_op = DM_OP_SH; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0000_5555;
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstw_busy", 32'(busy), 32'd0);
      chk("rstw_done", 32'(done), 32'd0);
      chk("rstw_rdata", rdata, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rstw_we_cnt", 32'(we_cnt - w0), 32'd0);
      chk("rstw_ram", ram[4], 32'h1122_AA44);

      // Back-to-back loads with req_valid held.
      do_req(DM_OP_WD, 1'b0, 32'h10, 32'h0, 1, lat, rd, mis);
      chk("b2b0_rdata", rd, 32'h1122_AA44); chk("b2b0_lat", 32'(lat), 32'd3);
      do_req(DM_OP_UB, 1'b0, 32'h20, 32'h0, 1, lat, rd, mis);
      chk("b2b1_rdata", rd, 32'h0000_0001); chk("b2b1_lat", 32'(lat), 32'd3);
      do_req(DM_OP_WD, 1'b0, 32'h14, 32'h0, 0, lat, rd, mis);
      chk("b2b2_rdata", rd, 32'hDEAD_BEEF); chk("b2b2_lat", 32'(lat), 32'd3);

      // Random traffic in a small window so accesses collide; model checks every cycle.
      for (int i = 0; i < 150; i++) begin
         bit hold;
         logic [31:0] a;
         hold = (i != 149) && ($urandom_range(0, 1) == 1);
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         do_req(3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), a, $urandom, hold,
                lat, rd, mis);
         if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      repeat (2) @(posedge clk);
      #1;
      for (int w = 0; w < 16; w++) chk("ram_final", ram[w], ram_ref_word(w));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [31:0] ram_ref_word(input int w);
      return {ref_b[w*4+3], ref_b[w*4+2], ref_b[w*4+1], ref_b[w*4]};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
